alu_issue_unit: RTL and testbench
=================================

# alu_issue_unit

Issue and writeback stage for the single-cycle integer ALU. Accepts one RV32I OP / OP-IMM instruction word per handshake and decodes it. It reads operands from an internal 32×32 register file, drives the ALU's `en` / `i` / `op0` / `op1` / `opcode` inputs, and writes the ALU result back to `rd`. Instructions are strictly serialised, so there are no hazards.

## Interface
Parameters:
- `XLEN`, 32: datapath width; only 32 is supported.
- `NREGS`, 32: register count; x0 is hardwired to zero.

Ports:
- `clk`  in  1  clock; all state changes on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `instr_valid`  in  1  instruction word is valid.
- `instr_ready`  out  1  unit can accept; high only in IDLE.
- `instr`  in  32  RV32I instruction word.
- `alu_en`  out  1  ALU strobe; the ALU computes on its rising edge.
- `alu_i`  out  1  legal-op qualifier to the ALU.
- `alu_op0`  out  32  rs1 value.
- `alu_op1`  out  32  rs2 value or sign-extended immediate.
- `alu_opcode`  out  4  ALU operation code.
- `alu_result`  in  32  ALU result.
- `wb_valid`  out  1  one-cycle writeback pulse.
- `wb_rd`  out  5  destination register.
- `wb_data`  out  32  value written.
- `illegal`  out  1  one-cycle pulse for an undecodable instruction.

## Operation
FSM states: IDLE, EXEC, WB.
- **IDLE:**
  - `instr_ready`=1.
  - On `instr_valid`, latch `instr` fields, the rs1/rs2 read data, the immediate and the opcode.
  - Next state is EXEC if the instruction is legal. Otherwise `illegal` pulses for one cycle and the FSM stays in IDLE.
- **EXEC:**
  - `alu_en`=1 and `alu_i`=1 for exactly one cycle.
  - Next state is WB.
- **WB:**
  - `alu_en`=0, `wb_valid`=1, `wb_rd`=rd, `wb_data`=`alu_result`.
  - The register file is written on the edge that leaves WB, unless rd=0.
  - Next state is IDLE.

Decode rules:
- Opcode mapping: `alu_opcode` = {funct3, b}.
  - R-type (0110011): b = funct7[5].
  - I-type (0010011): b = instr[30] only when funct3 is 101; b=0 otherwise. ADDI with imm[10]=1 is therefore never decoded as SUB.
  - Resulting codes: ADD 0000, SUB 0001, SLL 0010, SLT 0100, SLTU 0110, XOR 1000, SRL 1010, SRA 1011, OR 1100, AND 1110.
- Illegal instructions:
  - Major opcode other than 0110011 or 0010011.
  - R-type with funct7 not 0000000 or 0100000.
  - R-type with funct7=0100000 and funct3 not 000 or 101.
  - I-type funct3=001 with instr[31:25]≠0.
  - I-type funct3=101 with instr[31:25] not 0000000 or 0100000.
- Immediate: sign-extended `instr[31:20]`. For shifts, `alu_op1[4:0]` carries the shamt.
- Register file: rs1 and rs2 are read combinationally during the IDLE accept cycle. A read of x0 always returns 0.

## Timing
- Reset values: state=IDLE, `instr_ready`=1, `alu_en`=0, `alu_i`=0, `alu_op0`=0, `alu_op1`=0, `alu_opcode`=0, `wb_valid`=0, `wb_rd`=0, `wb_data`=0, `illegal`=0. All 31 writable registers are cleared to 0.
- Latency: for an accept at edge t0, `alu_en` is high during t0–t1, `wb_valid` is high during t1–t2, and the register file is updated at t2. `instr_ready` returns high after t2.
- Throughput: one instruction per 3 cycles. An illegal instruction occupies 1 cycle.
- `alu_op0`, `alu_op1` and `alu_opcode` stay stable from t0 until the next accept.
- The ALU result is sampled only in WB. It settles after the `alu_en` rise, one full cycle earlier.
- Back-to-back RAW dependencies need no bypass: the next accept (at or after t2) reads the updated register file.
- rd=x0: `wb_valid` still pulses with `wb_rd`=0 and the register file is unchanged.
- `rst` in EXEC or WB aborts the instruction: no write, `alu_en` drops on the reset edge, the FSM returns to IDLE and the register file clears.
- `instr_valid` held high while not ready has no effect. Words are consumed only in IDLE.

## Structure
- Shared package `alu_pkg` holds:
  - ALU opcode localparams: `ALU_ADD`…`ALU_AND`.
  - Major opcodes: `OPC_OP`=0110011, `OPC_OPIMM`=0010011.
  - The FSM state encoding.
- Sub-module `regfile_2r1w`: `clk`, `rst`, two combinational read ports, one synchronous write port, x0 hardwired to zero.
- Decode logic and the FSM live in `alu_issue_unit`.

## Test plan
- **Reset, then ADDI x1,x0,5 (0x00500093):** `alu_opcode`=0000, `alu_op1`=5, one-cycle `alu_en`, `wb_valid` with `wb_rd`=1 and `wb_data`=5; x1=5.
- **Dependent R-type:** after x1=5, issue ADDI x2,x0,-3 then SUB x3,x1,x2. Opcode 0001, `wb_data`=8. SLT x4,x2,x1 gives 1; SLTU x5,x2,x1 gives 0.
- **Shifts:** x2=0xFFFFFFFD. SRAI x6,x2,1 (instr[30]=1) gives opcode 1011 and 0xFFFFFFFE. SRLI gives opcode 1010 and 0x7FFFFFFE. ADDI with imm=0x400 gives opcode 0000, not 0001.
- **Illegal:** a load word (opcode 0000011), or R-type with funct7=0100000 and funct3=111, pulses `illegal` for 1 cycle with no `alu_en`, no `wb_valid` and no register write.
- **x0 destination:** ADDI x0,x0,7 pulses `wb_valid` with `wb_rd`=0. A following ADD x7,x0,x0 writes 0.
- **Reset mid-op:** assert `rst` during EXEC. `alu_en` is 0 after the edge, `wb_valid` never fires, and x1 reads back 0 afterwards.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue/writeback stage: ALU operation codes,
// RV32I major opcodes, FSM state encoding and the instruction decoder.
package alu_pkg;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_SLL  = 4'b0010;
  localparam logic [3:0] ALU_SLT  = 4'b0100;
  localparam logic [3:0] ALU_SLTU = 4'b0110;
  localparam logic [3:0] ALU_XOR  = 4'b1000;
  localparam logic [3:0] ALU_SRL  = 4'b1010;
  localparam logic [3:0] ALU_SRA  = 4'b1011;
  localparam logic [3:0] ALU_OR   = 4'b1100;
  localparam logic [3:0] ALU_AND  = 4'b1110;

  localparam logic [6:0] OPC_OP    = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM = 7'b0010011;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_WB   = 2'd2
  } state_e;

  typedef struct packed {
    logic       legal;
    logic       use_imm;
    logic [3:0] opcode;
  } decode_t;

  // The ALU opcode is {funct3, b}. For OP-IMM only the right shifts carry a
  // meaningful instr[30]; everywhere else that bit is immediate data, which
  // keeps ADDI with imm[10]=1 from turning into SUB.
  function automatic decode_t decode_instr(input logic [31:0] w);
    decode_t    d;
    logic [2:0] f3;
    logic [6:0] f7;
    f3 = w[14:12];
    f7 = w[31:25];
    d  = '0;
    case (w[6:0])
      OPC_OP: begin
        d.opcode = {f3, f7[5]};
        d.legal  = (f7 == 7'b0000000) ||
                   ((f7 == 7'b0100000) && ((f3 == 3'b000) || (f3 == 3'b101)));
      end
      OPC_OPIMM: begin
        d.use_imm = 1'b1;
        d.opcode  = {f3, (f3 == 3'b101) & w[30]};
        case (f3)
          3'b001:  d.legal = (f7 == 7'b0000000);
          3'b101:  d.legal = (f7 == 7'b0000000) || (f7 == 7'b0100000);
          default: d.legal = 1'b1;
        endcase
      end
      default: d = '0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/regfile_2r1w.sv
// Integer register file: two combinational read ports, one synchronous write
// port, x0 hardwired to zero, all registers cleared by reset.
module regfile_2r1w #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  parameter int AW    = $clog2(NREGS)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [AW-1:0]   rs1_addr,
  output logic [XLEN-1:0] rs1_data,
  input  logic [AW-1:0]   rs2_addr,
  output logic [XLEN-1:0] rs2_data,
  input  logic            wr_en,
  input  logic [AW-1:0]   wr_addr,
  input  logic [XLEN-1:0] wr_data
);

  logic [XLEN-1:0] mem_q [NREGS];
  logic [XLEN-1:0] mem_d [NREGS];

  // Next-state of the array: hold, apply the single write, keep x0 at zero.
  always_comb begin
    mem_d = mem_q;
    if (wr_en && (wr_addr != '0)) begin
      mem_d[wr_addr] = wr_data;
    end
    mem_d[0] = '0;
  end

  // Register array update with synchronous clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the architectural state must be zero after reset, so the whole
      // array is cleared here; this forces flops rather than a RAM macro.
      for (int i = 0; i < NREGS; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      mem_q <= mem_d;
    end
  end

  // Combinational reads; x0 is decoded explicitly.
  always_comb begin
    rs1_data = (rs1_addr == '0) ? '0 : mem_q[rs1_addr];
    rs2_data = (rs2_addr == '0) ? '0 : mem_q[rs2_addr];
  end

endmodule

// File: rtl/alu_issue_unit.sv
// Issue and writeback stage for the single-cycle integer ALU. Accepts one
// OP / OP-IMM word in IDLE, drives the ALU for one EXEC cycle and writes the
// result back to rd in WB. Instructions are fully serialised.
module alu_issue_unit
  import alu_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int NREGS = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            instr_valid,
  output logic            instr_ready,
  input  logic [31:0]     instr,
  output logic            alu_en,
  output logic            alu_i,
  output logic [XLEN-1:0] alu_op0,
  output logic [XLEN-1:0] alu_op1,
  output logic [3:0]      alu_opcode,
  input  logic [XLEN-1:0] alu_result,
  output logic            wb_valid,
  output logic [4:0]      wb_rd,
  output logic [XLEN-1:0] wb_data,
  output logic            illegal
);

  state_e          state_q, state_d;
  logic [XLEN-1:0] op0_q, op0_d;
  logic [XLEN-1:0] op1_q, op1_d;
  logic [3:0]      opcode_q, opcode_d;
  logic [4:0]      rd_q, rd_d;
  logic            illegal_q, illegal_d;

  decode_t         dec;
  logic [XLEN-1:0] rs1_data;
  logic [XLEN-1:0] rs2_data;
  logic [XLEN-1:0] imm_sext;
  logic            rf_we;

  assign dec      = decode_instr(instr);
  assign imm_sext = {{(XLEN-12){instr[31]}}, instr[31:20]};
  // Write happens on the edge that leaves WB; the register file ignores x0.
  assign rf_we    = (state_q == ST_WB);

  regfile_2r1w #(
    .XLEN  (XLEN),
    .NREGS (NREGS)
  ) u_regfile (
    .clk      (clk),
    .rst      (rst),
    .rs1_addr (instr[19:15]),
    .rs1_data (rs1_data),
    .rs2_addr (instr[24:20]),
    .rs2_data (rs2_data),
    .wr_en    (rf_we),
    .wr_addr  (rd_q),
    .wr_data  (alu_result)
  );

  // Next-state and operand capture: operands are latched only on a legal
  // accept so they stay stable until the next instruction is taken.
  always_comb begin
    // NOTE: every variable gets its hold value first so no path through the
    // case below leaves one unassigned, which would infer a latch.
    state_d   = state_q;
    op0_d     = op0_q;
    op1_d     = op1_q;
    opcode_d  = opcode_q;
    rd_d      = rd_q;
    illegal_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (instr_valid) begin
          if (dec.legal) begin
            state_d  = ST_EXEC;
            op0_d    = rs1_data;
            op1_d    = dec.use_imm ? imm_sext : rs2_data;
            opcode_d = dec.opcode;
            rd_d     = instr[11:7];
          end else begin
            illegal_d = 1'b1;
          end
        end
      end
      ST_EXEC: state_d = ST_WB;
      ST_WB:   state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q   <= ST_IDLE;
      op0_q     <= '0;
      op1_q     <= '0;
      opcode_q  <= '0;
      rd_q      <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      op0_q     <= op0_d;
      op1_q     <= op1_d;
      opcode_q  <= opcode_d;
      rd_q      <= rd_d;
      illegal_q <= illegal_d;
    end
  end

  // Outputs decoded from the registered state; writeback fields read zero
  // outside WB.
  always_comb begin
    instr_ready = (state_q == ST_IDLE);
    alu_en      = (state_q == ST_EXEC);
    alu_i       = (state_q == ST_EXEC);
    alu_op0     = op0_q;
    alu_op1     = op1_q;
    alu_opcode  = opcode_q;
    wb_valid    = (state_q == ST_WB);
    wb_rd       = (state_q == ST_WB) ? rd_q : 5'd0;
    wb_data     = (state_q == ST_WB) ? alu_result : '0;
    illegal     = illegal_q;
  end

endmodule

// File: tb/tb_alu_issue_unit.sv
// Bench for alu_issue_unit: directed scenarios plus randomized OP / OP-IMM
// traffic, checked against an instruction-level register model.
module tb_alu_issue_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic        alu_en;
  logic        alu_i;
  logic [31:0] alu_op0;
  logic [31:0] alu_op1;
  logic [3:0]  alu_opcode;
  logic [31:0] alu_result = 32'd0;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        illegal;

  int passed = 0;
  int total  = 0;

  logic [31:0] regs [32];

  alu_issue_unit #(.XLEN(32), .NREGS(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr       (instr),
    .alu_en      (alu_en),
    .alu_i       (alu_i),
    .alu_op0     (alu_op0),
    .alu_op1     (alu_op1),
    .alu_opcode  (alu_opcode),
    .alu_result  (alu_result),
    .wb_valid    (wb_valid),
    .wb_rd       (wb_rd),
    .wb_data     (wb_data),
    .illegal     (illegal)
  );

  always #5 clk = ~clk;

  // Environment ALU: computes on the rising edge while alu_en is high.
  function automatic logic [31:0] alu_env(input logic [3:0] code,
                                          input logic [31:0] a,
                                          input logic [31:0] b);
    case (code)
      4'b0000: return a + b;
      4'b0001: return a - b;
      4'b0010: return a << b[4:0];
      4'b0100: return {31'd0, $signed(a) < $signed(b)};
      4'b0110: return {31'd0, a < b};
      4'b1000: return a ^ b;
      4'b1010: return a >> b[4:0];
      4'b1011: return $signed(a) >>> b[4:0];
      4'b1100: return a | b;
      4'b1110: return a & b;
      default: return 32'hDEADBEEF;
    endcase
  endfunction

  always @(posedge clk) begin
    if (alu_en) alu_result <= alu_env(alu_opcode, alu_op0, alu_op1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  // ---------------- reference model (instruction level) ----------------
  function automatic bit ref_is_r(input logic [31:0] w);
    return w[6:0] == 7'b0110011;
  endfunction

  function automatic bit ref_legal(input logic [31:0] w);
    logic [2:0] f3;
    logic [6:0] f7;
    f3 = w[14:12];
    f7 = w[31:25];
    if (w[6:0] == 7'b0110011)
      return (f7 == 7'h00) || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5));
    if (w[6:0] == 7'b0010011) begin
      if (f3 == 3'd1) return f7 == 7'h00;
      if (f3 == 3'd5) return (f7 == 7'h00) || (f7 == 7'h20);
      return 1'b1;
    end
    return 1'b0;
  endfunction

  function automatic logic [31:0] ref_op1(input logic [31:0] w);
    if (ref_is_r(w)) return regs[w[24:20]];
    return {{20{w[31]}}, w[31:20]};
  endfunction

  function automatic logic [3:0] ref_opcode(input logic [31:0] w);
    if (ref_is_r(w)) return {w[14:12], w[30]};
    return {w[14:12], (w[14:12] == 3'd5) ? w[30] : 1'b0};
  endfunction

  function automatic logic [31:0] ref_result(input logic [31:0] w);
    logic [31:0] a, b;
    a = regs[w[19:15]];
    b = ref_op1(w);
    case (w[14:12])
      3'd0: begin
        if (ref_is_r(w) && w[30]) return a - b;
        return a + b;
      end
      3'd1: return a << b[4:0];
      3'd2: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      3'd3: return (a < b) ? 32'd1 : 32'd0;
      3'd4: return a ^ b;
      3'd5: begin
        if (w[30]) return $signed(a) >>> b[4:0];
        return a >> b[4:0];
      end
      3'd6: return a | b;
      default: return a & b;
    endcase
  endfunction

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3,
                                        input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'b0110011};
  endfunction

  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd);
    return {imm, rs1, f3, rd, 7'b0010011};
  endfunction

  // Issue one word starting at a falling edge; optionally keep instr_valid
  // high with garbage words while the unit is busy.
  task automatic run_instr(input logic [31:0] w, input bit hold_busy);
    bit          legal;
    logic [4:0]  rd;
    logic [31:0] e_op0, e_op1, e_res;
    logic [3:0]  e_code;
    legal  = ref_legal(w);
    rd     = w[11:7];
    e_op0  = regs[w[19:15]];
    e_op1  = ref_op1(w);
    e_code = ref_opcode(w);
    e_res  = ref_result(w);
    instr       = w;
    instr_valid = 1'b1;
    check("ready_before", 32'(instr_ready), 32'd1);
    @(posedge clk); @(negedge clk);
    if (!legal) begin
      instr_valid = 1'b0;
      check("illegal_pulse", 32'(illegal), 32'd1);
      check("illegal_no_en", 32'(alu_en), 32'd0);
      check("illegal_ready", 32'(instr_ready), 32'd1);
      @(posedge clk); @(negedge clk);
      check("illegal_drop", 32'(illegal), 32'd0);
      check("illegal_no_wb", 32'(wb_valid), 32'd0);
      return;
    end
    if (hold_busy) instr = $urandom;
    else instr_valid = 1'b0;
    check("exec_en", 32'(alu_en), 32'd1);
    check("exec_i", 32'(alu_i), 32'd1);
    check("exec_opcode", 32'(alu_opcode), 32'(e_code));
    check("exec_op0", alu_op0, e_op0);
    check("exec_op1", alu_op1, e_op1);
    check("exec_busy", 32'(instr_ready), 32'd0);
    check("exec_no_wb", 32'(wb_valid), 32'd0);
    check("exec_no_ill", 32'(illegal), 32'd0);
    @(posedge clk); @(negedge clk);
    check("wb_en_low", 32'(alu_en), 32'd0);
    check("wb_valid", 32'(wb_valid), 32'd1);
    check("wb_rd", 32'(wb_rd), 32'(rd));
    check("wb_data", wb_data, e_res);
    check("wb_opcode_stable", 32'(alu_opcode), 32'(e_code));
    check("wb_busy", 32'(instr_ready), 32'd0);
    if (rd != 5'd0) regs[rd] = e_res;
    @(posedge clk); @(negedge clk);
    instr_valid = 1'b0;
    check("post_ready", 32'(instr_ready), 32'd1);
    check("post_no_wb", 32'(wb_valid), 32'd0);
    check("post_no_en", 32'(alu_en), 32'd0);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) regs[i] = 32'd0;
  endtask

  function automatic logic [31:0] rand_word();
    int          kind;
    logic [6:0]  f7;
    logic [2:0]  f3;
    logic [4:0]  rd, rs1, rs2;
    logic [11:0] imm;
    kind = $urandom_range(0, 9);
    f3   = 3'($urandom_range(0, 7));
    rd   = 5'($urandom_range(0, 7));
    rs1  = 5'($urandom_range(0, 7));
    rs2  = 5'($urandom_range(0, 7));
    imm  = 12'($urandom);
    case ($urandom_range(0, 3))
      0, 1: f7 = 7'h00;
      2:    f7 = 7'h20;
      default: f7 = 7'($urandom);
    endcase
    if (kind == 0) return $urandom;
    if (kind <= 4) return enc_r(f7, rs2, rs1, f3, rd);
    if (f3 == 3'd1 || f3 == 3'd5) imm[11:5] = f7;
    return enc_i(imm, rs1, f3, rd);
  endfunction

  initial begin
    rst         = 1'b1;
    instr_valid = 1'b0;
    instr       = 32'd0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Reset state
    check("rst_ready", 32'(instr_ready), 32'd1);
    check("rst_en", 32'(alu_en), 32'd0);
    check("rst_i", 32'(alu_i), 32'd0);
    check("rst_op0", alu_op0, 32'd0);
    check("rst_op1", alu_op1, 32'd0);
    check("rst_opcode", 32'(alu_opcode), 32'd0);
    check("rst_wb_valid", 32'(wb_valid), 32'd0);
    check("rst_wb_rd", 32'(wb_rd), 32'd0);
    check("rst_wb_data", wb_data, 32'd0);
    check("rst_illegal", 32'(illegal), 32'd0);

    // ADDI x1,x0,5 then dependent R-type ops
    run_instr(32'h00500093, 1'b0);
    check("x1_is_5", regs[1], 32'd5);
    run_instr(enc_i(12'hFFD, 5'd0, 3'd0, 5'd2), 1'b0);
    run_instr(enc_r(7'h20, 5'd2, 5'd1, 3'd0, 5'd3), 1'b0);
    check("sub_gives_8", regs[3], 32'd8);
    run_instr(enc_r(7'h00, 5'd1, 5'd2, 3'd2, 5'd4), 1'b0);
    check("slt_gives_1", regs[4], 32'd1);
    run_instr(enc_r(7'h00, 5'd1, 5'd2, 3'd3, 5'd5), 1'b0);
    check("sltu_gives_0", regs[5], 32'd0);

    // Shifts and ADDI with imm[10] set
    run_instr(enc_i({7'h20, 5'd1}, 5'd2, 3'd5, 5'd6), 1'b0);
    check("srai_value", regs[6], 32'hFFFFFFFE);
    run_instr(enc_i(12'd1, 5'd2, 3'd5, 5'd6), 1'b1);
    check("srli_value", regs[6], 32'h7FFFFFFE);
    run_instr(enc_i(12'h400, 5'd0, 3'd0, 5'd7), 1'b0);
    check("addi_400", regs[7], 32'h00000400);

    // Illegal words; prove no write by reading the targets back
    run_instr(32'h00002083, 1'b0);
    run_instr(enc_r(7'h20, 5'd2, 5'd1, 3'd7, 5'd3), 1'b0);
    run_instr(enc_i(12'd0, 5'd1, 3'd0, 5'd9), 1'b0);
    check("x1_after_illegal", regs[9], 32'd5);
    run_instr(enc_i(12'd0, 5'd3, 3'd0, 5'd9), 1'b0);
    check("x3_after_illegal", regs[9], 32'd8);

    // x0 destination
    run_instr(enc_i(12'd7, 5'd0, 3'd0, 5'd0), 1'b0);
    run_instr(enc_r(7'h00, 5'd0, 5'd0, 3'd0, 5'd7), 1'b0);
    check("add_x0_x0", regs[7], 32'd0);

    // Reset during EXEC aborts the instruction and clears the register file
    instr       = enc_i(12'd9, 5'd1, 3'd0, 5'd1);
    instr_valid = 1'b1;
    @(posedge clk); @(negedge clk);
    instr_valid = 1'b0;
    check("abort_in_exec", 32'(alu_en), 32'd1);
    rst = 1'b1;
    @(posedge clk); @(negedge clk);
    rst = 1'b0;
    model_reset();
    check("abort_en_low", 32'(alu_en), 32'd0);
    check("abort_no_wb", 32'(wb_valid), 32'd0);
    check("abort_ready", 32'(instr_ready), 32'd1);
    @(posedge clk); @(negedge clk);
    check("abort_no_wb_later", 32'(wb_valid), 32'd0);
    run_instr(enc_i(12'd0, 5'd1, 3'd0, 5'd8), 1'b0);
    check("x1_cleared", regs[8], 32'd0);

    // Randomized traffic
    for (int n = 0; n < 300; n++) begin
      run_instr(rand_word(), 1'($urandom_range(0, 1)));
    end
    // Read back x1..x7 through ADDI xN,xN,0 to compare against the model
    for (int r = 1; r < 8; r++) begin
      run_instr(enc_i(12'd0, 5'(r), 3'd0, 5'(r)), 1'b0);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
